// File: rtl/ina220_uart_framer.sv
`timescale 1ns/1ps
// ina220_uart_framer
// Captures each 16-bit INA220 result on the rising edge of DATA_EN and sends
// it to CoreUART as a 5-byte frame: HDR, SEQ, MSB, LSB, CHK.
// A one-deep pending buffer holds a result that arrives while a frame is
// still being sent; overwriting an unsent result raises a sticky OVERFLOW.
module ina220_uart_framer #(
    parameter logic [7:0] HDR = 8'hAA
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [15:0] INA220_DATA,
    input  logic        DATA_EN,
    input  logic        TXRDY,
    input  logic        OVF_CLR,
    output logic [7:0]  UART_DATA,
    output logic        UART_WEN_N,
    output logic        BUSY,
    output logic        OVERFLOW
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [1:0]  state;
    logic [2:0]  idx;
    logic [2:0]  idx_nx;
    logic [7:0]  seq;
    logic        en_d;
    logic        cap;
    logic        load;
    logic [15:0] pend;
    logic        pend_v;
    logic [15:0] frm_data;
    logic [7:0]  frm_chk;
    logic [7:0]  nx_byte;

    assign cap    = DATA_EN & ~en_d;
    assign load   = (state == ST_IDLE) & pend_v & TXRDY;
    assign idx_nx = idx + 3'd1;

    // Registered copy of DATA_EN for rising-edge detection.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block order.
    always_ff @(posedge PCLK) begin
        if (PRESET) en_d <= 1'b0;
        else        en_d <= DATA_EN;
    end

    // Pending result word; qualified by pend_v, so its content after reset is irrelevant.
    // NOTE: pure data registers are deliberately left without reset; a valid
    // flag alone decides whether they are meaningful.
    always_ff @(posedge PCLK) begin
        if (cap) pend <= INA220_DATA;
    end

    // Pending-valid flag and sticky overflow (set wins over clear).
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pend_v   <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (cap)       pend_v <= 1'b1;
            else if (load) pend_v <= 1'b0;

            if (cap && pend_v && !load) OVERFLOW <= 1'b1;
            else if (OVF_CLR)           OVERFLOW <= 1'b0;
        end
    end

    // Frame snapshot taken when IDLE starts a frame; CHK computed once here.
    always_ff @(posedge PCLK) begin
        if (load) begin
            frm_data <= pend;
            frm_chk  <= HDR + seq + pend[15:8] + pend[7:0];
        end
    end

    // Byte to present on the next WRITE, selected by the upcoming index.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        nx_byte = frm_chk;
        case (idx_nx)
            3'd0:    nx_byte = HDR;
            3'd1:    nx_byte = seq;
            3'd2:    nx_byte = frm_data[15:8];
            3'd3:    nx_byte = frm_data[7:0];
            default: nx_byte = frm_chk;
        endcase
    end

    // Frame sequencer; UART outputs and BUSY are registered alongside the state.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            seq        <= 8'h00;
            UART_DATA  <= 8'h00;
            UART_WEN_N <= 1'b1;
            BUSY       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        idx        <= 3'd0;
                        state      <= ST_WRITE;
                        UART_DATA  <= HDR;
                        UART_WEN_N <= 1'b0;
                        BUSY       <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_GUARD;
                    UART_WEN_N <= 1'b1;
                end
                ST_GUARD: begin
                    // CoreUART may still show TXRDY=1 for the byte just written.
                    state <= ST_WAIT;
                end
                default: begin
                    if (TXRDY) begin
                        if (idx == 3'd4) begin
                            seq   <= seq + 8'd1;
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            idx        <= idx_nx;
                            state      <= ST_WRITE;
                            UART_DATA  <= nx_byte;
                            UART_WEN_N <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ina220_uart_framer.sv
`timescale 1ns/1ps
// Testbench for ina220_uart_framer: directed scenarios with random payloads,
// a byte monitor and a frame-level reference model.
module tb_ina220_uart_framer;

    localparam logic [7:0] HDR = 8'hAA;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [15:0] INA220_DATA = 16'h0000;
    logic        DATA_EN = 1'b0;
    logic        TXRDY = 1'b1;
    logic        OVF_CLR = 1'b0;
    logic [7:0]  UART_DATA;
    logic        UART_WEN_N;
    logic        BUSY;
    logic        OVERFLOW;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] byte_q[$];
    int         cyc_q[$];
    bit         rand_rdy = 1'b0;
    logic [7:0] exp_seq = 8'h00;

    ina220_uart_framer #(.HDR(HDR)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .INA220_DATA (INA220_DATA),
        .DATA_EN     (DATA_EN),
        .TXRDY       (TXRDY),
        .OVF_CLR     (OVF_CLR),
        .UART_DATA   (UART_DATA),
        .UART_WEN_N  (UART_WEN_N),
        .BUSY        (BUSY),
        .OVERFLOW    (OVERFLOW)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Byte monitor: every cycle with the write strobe low is one byte sent.
    always @(negedge PCLK) begin
        if (UART_WEN_N === 1'b0) begin
            byte_q.push_back(UART_DATA);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference frame: header, sequence, data bytes, modulo-256 sum.
    function automatic logic [7:0] model_byte(input logic [7:0] s, input logic [15:0] d, input int i);
        int sum;
        sum = int'(HDR) + int'(s) + int'(d) / 256 + int'(d) % 256;
        case (i)
            0:       return HDR;
            1:       return s;
            2:       return 8'(int'(d) / 256);
            3:       return 8'(int'(d) % 256);
            default: return 8'(sum % 256);
        endcase
    endfunction

    task automatic tick();
        @(negedge PCLK);
        #1;
        if (rand_rdy) TXRDY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic [15:0] d, input int len);
        INA220_DATA = d;
        DATA_EN = 1'b1;
        ticks(len);
        DATA_EN = 1'b0;
    endtask

    task automatic clear_q();
        byte_q.delete();
        cyc_q.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (byte_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, byte_q.size(), n);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [15:0] d);
        logic [31:0] obs;
        for (int i = 0; i < 5; i++) begin
            obs = (base + i < byte_q.size()) ? {24'h0, byte_q[base + i]} : 32'hxxxx_xxxx;
            check(tag, obs, {24'h0, model_byte(exp_seq, d, i)});
        end
        exp_seq = exp_seq + 8'd1;
    endtask

    initial begin
        int          c0;
        int          r;
        int          last;
        logic [15:0] d1, d2, d3, d4, d5;

        // Reset state
        ticks(3);
        check("rst_wen_n", UART_WEN_N, 1);
        check("rst_busy", BUSY, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_data", UART_DATA, 8'h00);
        PRESET = 1'b0;
        ticks(2);

        // Single frame, TXRDY tied high: latency, spacing, BUSY fall
        clear_q();
        c0 = cyc;
        strobe(16'h1234, 1);
        wait_bytes(5, 40, "a_count");
        check_frame("a_byte", 0, 16'h1234);
        check("a_latency", cyc_q[0], c0 + 2);
        for (int i = 1; i < 5; i++) check("a_gap", cyc_q[i] - cyc_q[i-1], 3);
        last = cyc_q[4];
        while (cyc < last + 2) tick();
        check("a_busy_hold", BUSY, 1);
        tick();
        check("a_busy_fall", BUSY, 0);
        ticks(3);

        // 256 back-to-back zero-data frames: SEQ wraps through FF to 00
        for (int f = 0; f < 256; f++) begin
            clear_q();
            strobe(16'h0000, 1);
            wait_bytes(5, 40, "b_count");
            check_frame("b_byte", 0, 16'h0000);
        end
        ticks(10);

        // Random payloads with random TXRDY back-pressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 24; f++) begin
            clear_q();
            d1 = 16'($urandom);
            strobe(d1, 1);
            wait_bytes(5, 400, "c_count");
            check_frame("c_byte", 0, d1);
        end
        rand_rdy = 1'b0;
        TXRDY = 1'b1;
        ticks(20);
        check("c_ovf", OVERFLOW, 0);

        // Overwrite of pending result mid-frame: second frame carries CAFE
        clear_q();
        d1 = 16'($urandom);
        strobe(d1, 1);
        wait_bytes(2, 40, "d_count1");
        strobe(16'hBEEF, 1);
        wait_bytes(3, 40, "d_count2");
        check("d_ovf_pre", OVERFLOW, 0);
        strobe(16'hCAFE, 1);
        check("d_ovf_set", OVERFLOW, 1);
        wait_bytes(10, 80, "d_count3");
        check_frame("d_frame1", 0, d1);
        check_frame("d_frame2", 5, 16'hCAFE);
        ticks(30);
        check("d_no_more", byte_q.size(), 10);
        check("d_ovf_sticky", OVERFLOW, 1);
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        check("d_ovf_clr", OVERFLOW, 0);

        // Start held by TXRDY=0 in IDLE; overflow and clear together: set wins
        clear_q();
        TXRDY = 1'b0;
        d2 = 16'($urandom);
        d3 = 16'($urandom);
        strobe(d2, 1);
        ticks(2);
        OVF_CLR = 1'b1;
        strobe(d3, 1);
        OVF_CLR = 1'b0;
        check("e_ovf_setwins", OVERFLOW, 1);
        ticks(20);
        check("e_held_count", byte_q.size(), 0);
        check("e_held_busy", BUSY, 0);
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        check("e_ovf_clr", OVERFLOW, 0);
        TXRDY = 1'b1;
        wait_bytes(5, 40, "e_count");
        check_frame("e_byte", 0, d3);
        ticks(30);
        check("e_no_more", byte_q.size(), 5);

        // Capture in the same cycle IDLE loads: both frames sent, no overflow
        clear_q();
        TXRDY = 1'b0;
        d4 = 16'($urandom);
        d5 = 16'($urandom);
        strobe(d4, 1);
        ticks(2);
        TXRDY = 1'b1;
        strobe(d5, 1);
        wait_bytes(10, 80, "f_count");
        check_frame("f_frame1", 0, d4);
        check_frame("f_frame2", 5, d5);
        check("f_ovf", OVERFLOW, 0);
        ticks(5);

        // DATA_EN held high 10 cycles: exactly one frame
        clear_q();
        d1 = 16'($urandom);
        strobe(d1, 10);
        wait_bytes(5, 40, "g_count");
        ticks(40);
        check("g_one_frame", byte_q.size(), 5);
        check_frame("g_byte", 0, d1);

        // Stall in WAIT after byte 2: no strobe, byte 3 one cycle after TXRDY rises
        clear_q();
        d1 = 16'($urandom);
        strobe(d1, 1);
        wait_bytes(3, 40, "h_count1");
        TXRDY = 1'b0;
        ticks(50);
        check("h_stalled", byte_q.size(), 3);
        check("h_busy", BUSY, 1);
        TXRDY = 1'b1;
        r = cyc;
        wait_bytes(5, 40, "h_count2");
        check("h_resume", cyc_q[3], r + 1);
        check_frame("h_byte", 0, d1);
        ticks(5);

        // Reset during byte 3: frame aborted, SEQ restarts at 00
        clear_q();
        d1 = 16'($urandom);
        strobe(d1, 1);
        wait_bytes(4, 40, "i_count1");
        PRESET = 1'b1;
        tick();
        check("i_wen_n", UART_WEN_N, 1);
        check("i_busy", BUSY, 0);
        check("i_data", UART_DATA, 8'h00);
        PRESET = 1'b0;
        exp_seq = 8'h00;
        ticks(30);
        check("i_aborted", byte_q.size(), 4);
        clear_q();
        d2 = 16'($urandom);
        strobe(d2, 1);
        wait_bytes(5, 40, "i_count2");
        check_frame("i_byte", 0, d2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
